// File: rtl/sseg_scan_decoder.sv
// sseg_scan_decoder: loop-back monitor for a 4-digit multiplexed
// seven-segment bus; rebuilds the 16-bit hex value being displayed.
module sseg_scan_decoder #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:6]  sseg,
    input  logic [3:0]  an,
    output logic [15:0] num,
    output logic        valid,
    output logic        frame_stb,
    output logic        digit_err
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [3:0]    an_q;
    logic [0:6]    sseg_q;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmr;
    logic [3:0]    mask;
    logic [15:0]   stage;

    logic [1:0]    slot;
    logic          slot_ok;
    logic [3:0]    slot_bit;
    logic          sample;
    logic [3:0]    nib;
    logic          glyph_ok;
    logic [15:0]   stage_n;
    logic [3:0]    mask_n;
    logic          done;

    // Register the scanned bus once before any decision is made on it
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q   <= 4'b1111;
            sseg_q <= 7'b1111111;
        end else begin
            an_q   <= an;
            sseg_q <= sseg;
        end
    end

    // Count how long the anode pattern has been stable, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (an != an_q) begin
            cnt <= '0;
        end else if (cnt != CW'(SETTLE)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Map a one-hot-low anode pattern to its digit slot
    always_comb begin
        slot    = 2'd0;
        slot_ok = 1'b1;
        case (an_q)
            4'b1110: slot = 2'd0;
            4'b1101: slot = 2'd1;
            4'b1011: slot = 2'd2;
            4'b0111: slot = 2'd3;
            default: slot_ok = 1'b0;
        endcase
    end

    assign slot_bit = 4'b0001 << slot;
    assign sample   = slot_ok && (an == an_q) &&
                      (cnt == CW'(SETTLE - 1));

    // Translate the active-low a..g pattern into a hex nibble
    always_comb begin
        nib      = 4'h0;
        glyph_ok = 1'b1;
        case (sseg_q)
            7'b0000001: nib = 4'h0;
            7'b1001111: nib = 4'h1;
            7'b0010010: nib = 4'h2;
            7'b0000110: nib = 4'h3;
            7'b1001100: nib = 4'h4;
            7'b0100100: nib = 4'h5;
            7'b0100000: nib = 4'h6;
            7'b0001111: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0000100: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b1100000: nib = 4'hB;
            7'b0110001: nib = 4'hC;
            7'b1000010: nib = 4'hD;
            7'b0110000: nib = 4'hE;
            7'b0111000: nib = 4'hF;
            default:    glyph_ok = 1'b0;
        endcase
    end

    // Staging value with the freshly decoded nibble merged in
    always_comb begin
        stage_n = stage;
        case (slot)
            2'd0:    stage_n[3:0]   = nib;
            2'd1:    stage_n[7:4]   = nib;
            2'd2:    stage_n[11:8]  = nib;
            default: stage_n[15:12] = nib;
        endcase
    end

    assign mask_n = mask | slot_bit;
    assign done   = sample && glyph_ok && (mask_n == 4'b1111);

    // Capture digits, publish complete frames, flag bad glyphs
    always_ff @(posedge clk) begin
        if (rst) begin
            stage     <= '0;
            mask      <= '0;
            num       <= '0;
            frame_stb <= 1'b0;
            digit_err <= 1'b0;
        end else begin
            frame_stb <= 1'b0;
            digit_err <= 1'b0;
            if (sample) begin
                if (!glyph_ok) begin
                    digit_err <= 1'b1;
                end else if (done) begin
                    stage     <= stage_n;
                    num       <= stage_n;
                    mask      <= '0;
                    frame_stb <= 1'b1;
                end else begin
                    stage <= stage_n;
                    mask  <= mask_n;
                end
            end
        end
    end

    // Age the last frame; a completion on the same edge wins
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr   <= '0;
            valid <= 1'b0;
        end else if (done) begin
            tmr   <= '0;
            valid <= 1'b1;
        end else if (tmr != TW'(TIMEOUT)) begin
            tmr <= tmr + TW'(1);
            if (tmr == TW'(TIMEOUT - 1)) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// tb_sseg_scan_decoder: table vectors, corner sequences and random
// scanning checked every cycle against a dwell-based reference model.
module tb_sseg_scan_decoder;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:6]  sseg = 7'b1111111;
    logic [3:0]  an = 4'b1111;
    logic [15:0] num;
    logic        valid;
    logic        frame_stb;
    logic        digit_err;

    always #5 clk = ~clk;

    sseg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .sseg(sseg),
        .an(an),
        .num(num),
        .valid(valid),
        .frame_stb(frame_stb),
        .digit_err(digit_err)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    int last_stb = -1;
    int prev_stb = -1;

    logic [0:6] glyph [16];

    // reference model state
    logic [3:0]  m_stage [4];
    logic [3:0]  m_mask;
    logic [15:0] m_num;
    logic        m_valid, m_stb, m_err;
    int          m_tmr, m_run;
    logic [3:0]  m_an;
    logic [0:6]  m_sseg;

    typedef struct {
        logic [15:0] val;
        int          dwell;
        int          passes;
        logic [15:0] exp_num;
        int          exp_stb;
    } vec_t;

    vec_t vt [6];

    function automatic int lookup(input logic [0:6] p);
        for (int i = 0; i < 16; i++)
            if (glyph[i] == p) return i;
        return -1;
    endfunction

    function automatic int digit_of(input logic [3:0] a);
        logic [3:0] t;
        for (int i = 0; i < 4; i++) begin
            t = ~(4'b0001 << i);
            if (a == t) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // The model counts how many consecutive edges the present anode
    // pattern has been seen and samples after SETTLE+1 of them.
    task automatic model_edge();
        int k, v;
        logic fin;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_stage[i] = 4'h0;
            m_mask = 4'h0; m_num = 16'h0;
            m_valid = 0; m_stb = 0; m_err = 0;
            m_tmr = 0; m_run = 1;
            m_an = 4'hF; m_sseg = 7'b1111111;
        end else begin
            m_stb = 0; m_err = 0; fin = 0;
            if (an == m_an) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 1;
            end
            k = digit_of(an);
            if (m_run == SETTLE + 1 && k >= 0) begin
                v = lookup(m_sseg);
                if (v < 0) begin
                    m_err = 1;
                end else begin
                    m_stage[k] = v[3:0];
                    m_mask[k] = 1'b1;
                    if (m_mask == 4'hF) begin
                        m_num = {m_stage[3], m_stage[2],
                                 m_stage[1], m_stage[0]};
                        m_valid = 1; m_stb = 1; m_mask = 0; fin = 1;
                    end
                end
            end
            if (fin) begin
                m_tmr = 0;
            end else if (m_tmr < TIMEOUT) begin
                m_tmr++;
                if (m_tmr == TIMEOUT) m_valid = 0;
            end
            m_an = an; m_sseg = sseg;
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [0:6] s,
                        input logic r);
        an = a; sseg = s; rst = r;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        if (frame_stb === 1'b1) begin
            stb_cnt++; prev_stb = last_stb; last_stb = cyc;
        end
        if (digit_err === 1'b1) err_cnt++;
        check("cycle", {num, valid, frame_stb, digit_err},
              {m_num, m_valid, m_stb, m_err});
    endtask

    task automatic dwell(input int k, input logic [0:6] s, input int n);
        logic [3:0] a;
        a = ~(4'b0001 << k);
        repeat (n) step(a, s, 1'b0);
    endtask

    task automatic scan(input logic [15:0] v, input int d);
        for (int i = 0; i < 4; i++) dwell(i, glyph[v[i*4 +: 4]], d);
    endtask

    initial begin
        int s0, e0, fall;
        logic [15:0] prev_num;
        logic [15:0] bcd;

        glyph[0]  = 7'b0000001; glyph[1]  = 7'b1001111;
        glyph[2]  = 7'b0010010; glyph[3]  = 7'b0000110;
        glyph[4]  = 7'b1001100; glyph[5]  = 7'b0100100;
        glyph[6]  = 7'b0100000; glyph[7]  = 7'b0001111;
        glyph[8]  = 7'b0000000; glyph[9]  = 7'b0000100;
        glyph[10] = 7'b0001000; glyph[11] = 7'b1100000;
        glyph[12] = 7'b0110001; glyph[13] = 7'b1000010;
        glyph[14] = 7'b0110000; glyph[15] = 7'b0111000;

        vt[0] = '{16'h4321, 8, 3, 16'h4321, 3};
        vt[1] = '{16'hABCD, 5, 2, 16'hABCD, 2};
        vt[2] = '{16'h1234, 4, 2, 16'hABCD, 0};
        vt[3] = '{16'h0000, 6, 1, 16'h0000, 1};
        vt[4] = '{16'hFFFF, 9, 2, 16'hFFFF, 2};
        vt[5] = '{16'h8E6B, 1, 1, 16'hFFFF, 0};

        // reset with random bus activity
        for (int i = 0; i < 3; i++) begin
            step(4'($urandom), 7'($urandom), 1'b1);
            check("rst_num", num, 16'h0);
            check("rst_flags", {valid, frame_stb, digit_err}, 3'b000);
        end
        step(4'hF, 7'b1111111, 1'b0);

        // table-driven frames
        for (int i = 0; i < 6; i++) begin
            s0 = stb_cnt;
            for (int p = 0; p < vt[i].passes; p++)
                scan(vt[i].val, vt[i].dwell);
            check("tbl_num", num, vt[i].exp_num);
            check("tbl_stb", stb_cnt - s0, vt[i].exp_stb);
            if (vt[i].exp_stb > 1)
                check("tbl_period", last_stb - prev_stb, 4 * vt[i].dwell);
        end

        // decimal sweep at minimum dwell
        for (int v = 0; v < 100; v++) begin
            bcd = 16'((v / 10) * 16 + (v % 10));
            scan(bcd, SETTLE + 1);
            check("sweep", num, bcd);
        end

        // glitch on digit 2 is ignored
        s0 = stb_cnt; e0 = err_cnt;
        dwell(0, glyph[10], 8);
        dwell(1, glyph[11], 8);
        dwell(2, glyph[8], 3);
        step(4'hF, 7'b1111111, 1'b0);
        dwell(2, glyph[3], 8);
        dwell(3, glyph[12], 8);
        check("glitch_num", num, 16'hC3BA);
        check("glitch_stb", stb_cnt - s0, 1);
        check("glitch_err", err_cnt - e0, 0);

        // blank glyph on digit 1
        s0 = stb_cnt; e0 = err_cnt; prev_num = num;
        dwell(0, glyph[1], 8);
        dwell(1, 7'b1111111, 8);
        dwell(2, glyph[2], 8);
        dwell(3, glyph[3], 8);
        check("bad_err", err_cnt - e0, 1);
        check("bad_stb", stb_cnt - s0, 0);
        check("bad_num", num, prev_num);
        dwell(1, glyph[5], 8);
        check("bad_fix_stb", stb_cnt - s0, 1);
        check("bad_fix_num", num, 16'h3251);

        // timeout after blanking
        scan(16'h4321, 8);
        fall = -1;
        for (int i = 0; i < 200 && fall < 0; i++) begin
            step(4'hF, 7'b1111111, 1'b0);
            if (valid === 1'b0) fall = cyc;
        end
        check("timeout_seen", fall >= 0, 1);
        check("timeout_len", fall - last_stb, TIMEOUT);
        check("timeout_num", num, 16'h4321);

        // reset mid-frame discards partial digits
        dwell(0, glyph[4], 8);
        dwell(1, glyph[5], 8);
        step(4'hF, 7'b1111111, 1'b1);
        s0 = stb_cnt;
        dwell(2, glyph[6], 8);
        dwell(3, glyph[7], 8);
        check("rstmid_stb", stb_cnt - s0, 0);
        check("rstmid_valid", valid, 1'b0);
        dwell(0, glyph[4], 8);
        dwell(1, glyph[5], 8);
        check("rstmid_stb2", stb_cnt - s0, 1);
        check("rstmid_num", num, 16'h7654);
        check("rstmid_valid2", valid, 1'b1);

        // randomized scanning against the model
        for (int i = 0; i < 400; i++) begin
            int r, d, k;
            logic [3:0] a;
            logic [0:6] s;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step(4'($urandom), 7'($urandom), 1'b1);
            end else if (r < 5) begin
                repeat ($urandom_range(90, 130))
                    step(4'hF, 7'b1111111, 1'b0);
            end else begin
                k = $urandom_range(0, 3);
                a = ~(4'b0001 << k);
                if ($urandom_range(0, 99) < 12) a = 4'($urandom);
                s = glyph[$urandom_range(0, 15)];
                if ($urandom_range(0, 99) < 12) s = 7'($urandom);
                d = $urandom_range(1, 10);
                repeat (d) step(a, s, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sseg_scan_decoder.md
# sseg_scan_decoder

Receive-side monitor for the 4-digit multiplexed seven-segment bus driven by `display`. It samples the scanned `an`/`sseg` lines and reconstructs the 16-bit hex value that is being shown. It flags malformed segment patterns and drops `valid` when scanning stops. It runs in the same `clk` domain as the display driver and serves as a loop-back checker in benches and on-board self-test.

## Interface
- `SETTLE`, default 4: consecutive cycles an anode pattern must be stable before its segments are sampled; minimum 1.
- `TIMEOUT`, default 65535: cycles without a completed frame before `valid` is cleared; minimum 1.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sseg`  in  [0:6]  segments, active-low; `sseg[0]`=a … `sseg[6]`=g.
- `an`  in  [3:0]  digit enables, active-low one-hot; `an[0]` selects `num[3:0]`, `an[3]` selects `num[15:12]`.
- `num`  out  16  last complete decoded value.
- `valid`  out  1  `num` is from a frame completed within `TIMEOUT` cycles.
- `frame_stb`  out  1  one-cycle pulse when `num` is updated.
- `digit_err`  out  1  one-cycle pulse when a sampled segment pattern is not a hex glyph.

## Operation
- **Input registration:** `an` and `sseg` are registered once into `an_q` and `sseg_q`. Reset values: `an_q` = 4'b1111, `sseg_q` = 7'b1111111.
- **Settle counter `cnt`:**
  - If `an` != `an_q`, `cnt` is set to 0.
  - Otherwise `cnt` increments and saturates at `SETTLE`.
  - A sample event occurs on the edge where `cnt` goes from `SETTLE-1` to `SETTLE`, provided `an_q` is one of 1110, 1101, 1011, 0111.
  - At most one sample per dwell.
  - `an_q` = 1111 (blanking) or any other non-one-hot value never samples.
- **Glyph decode:** the table below maps `sseg_q` (a..g order, active-low) to a value. Any other pattern, including all-off, causes `digit_err` to pulse; the digit is not captured and its mask bit is unchanged.
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- **Capture:**
  - A valid sample writes its nibble into staging register slot k and sets `mask[k]`.
  - Re-sampling slot k before the frame completes overwrites that slot (latest wins).
- **Frame completion:**
  - When the capture makes `mask` = 1111, then on the same edge:
    - `num` <= staging value, including the nibble just decoded;
    - `valid` <= 1;
    - `frame_stb` <= 1 for one cycle;
    - `mask` <= 0;
    - timeout timer <= 0.
  - Digit order is irrelevant; any order completes a frame.
- **Timeout timer:**
  - Increments every cycle and saturates at `TIMEOUT`.
  - `valid` <= 0 on the edge where the timer reaches `TIMEOUT`.
  - `num` holds its value.
  - Completion on the same edge wins: the timer clears and `valid` stays 1.
- **Reset:** `num` = 0, `valid` = 0, `frame_stb` = 0, `digit_err` = 0, `mask` = 0, `cnt` = 0, timer = 0, staging = 0. Reset asserted mid-frame discards partial digits.

## Timing
- `an`/`sseg` change set up before edge E0: `an_q` updates and `cnt` = 0 at E0; the sample occurs at edge E0+`SETTLE`.
- Input-to-`num` latency for the final digit is `SETTLE`+1 edges from first presentation. For example, with `SETTLE`=4 the capture is at the 5th edge.
- `sseg` must be stable from E0 through the sample edge; the value sampled is `sseg_q` at that edge.
- A dwell shorter than `SETTLE`+1 cycles is ignored.
- `frame_stb` and `digit_err` are registered, one cycle wide, and never asserted together for the same sample.
- Continuous scanning at dwell D yields one `frame_stb` every 4·D cycles.

## Test plan
1. **Reset:** hold `rst`=1 for 3 cycles with random `an`/`sseg` -> `num`=0, `valid`=0, `frame_stb`=0, `digit_err`=0 after the first edge.
2. **Normal frame:** `SETTLE`=4, scan value 16'h4321 on digits 0..3 with a dwell of 8 cycles each -> `num`=16'h4321 and `valid`=1 at the 5th edge of digit 3's dwell, one `frame_stb` pulse; repeated scanning gives one pulse per 32 cycles. Sweeping `num` 0..99 through `display` -> `num` tracks each value.
3. **Glitch rejection:** a 3-cycle dwell on digit 2 showing 8 (0000000), then a normal dwell showing 3 -> nibble 2 = 3; no capture from the glitch.
4. **Bad glyph:** digit 1 driven as 1111111 -> one `digit_err` pulse, no `frame_stb`, `num` unchanged. Scanning digit 1 again correctly -> frame completes.
5. **Timeout:** `TIMEOUT`=100; after a frame completes, set `an`=1111 -> `valid` falls exactly 100 edges after the completion edge, and `num` holds 16'h4321.
6. **Reset mid-frame:** capture digits 0 and 1, pulse `rst`, then capture digits 2 and 3 only -> no `frame_stb` until digits 0 and 1 are also recaptured.
